// File: rtl/t_ff.sv
// t_ff: WIDTH independent toggle flip-flops with a registered "any bit toggled"
// pulse and an optional saturating toggle-event counter.
// Optional feature macro: T_FF_TOGGLE_CNT_EN -- when defined, toggle_cnt counts
// clock edges on which any bit toggled (saturating at all-ones); when undefined,
// toggle_cnt is tied to zero and no counter register exists.
// reset is asynchronous and active-low.
module t_ff #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             toggled,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             toggled_q;
    logic             toggled_d;
    logic             any_toggle_s;

    // Any requested toggle this edge; drives both the pulse and the counter.
    assign any_toggle_s = |t;

    // Next state of the flip-flop bits and the toggle pulse.
    always_comb begin
        q_d       = q_q ^ t;
        toggled_d = any_toggle_s;
    end

    // State register: reset clears all bits and the pulse immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q       <= {WIDTH{1'b0}};
            toggled_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            toggled_q <= toggled_d;
        end
    end

    // qb is derived from the same register so it can never disagree with q.
    assign q       = q_q;
    assign qb      = ~q_q;
    assign toggled = toggled_q;

`ifdef T_FF_TOGGLE_CNT_EN

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating increment: holds at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Counter next state: one count per edge with any toggle, however many bits.
    always_comb begin
        cnt_d = cnt_q;
        if (any_toggle_s) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register, cleared asynchronously with the flip-flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign toggle_cnt = cnt_q;

`else

    // Counter feature not built: constant zero, no storage.
    assign toggle_cnt = {CNT_W{1'b0}};

`endif

endmodule

// File: tb/tb_t_ff.sv
// Self-checking bench for t_ff: randomized toggle requests, a behavioural model
// pushing expected outputs into a scoreboard queue, and an independent monitor
// that pops and compares one entry after every rising clock edge.
module tb_t_ff;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             toggled;
    logic [CNT_W-1:0] toggle_cnt;

    typedef struct {
        int q;
        int qb;
        int tog;
        int cnt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errs   = 0;

    // behavioural model state
    int m_q   = 0;
    int m_cnt = 0;

    t_ff #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .t          (t),
        .q          (q),
        .qb         (qb),
        .toggled    (toggled),
        .toggle_cnt (toggle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.q   = 0;
        e.qb  = (1 << WIDTH) - 1;
        e.tog = 0;
        e.cnt = 0;
        return e;
    endfunction

    // One cycle: glitch t after the edge (must be ignored), then drive the real
    // value at the falling edge and push what the next rising edge should show.
    task automatic step(input int tv, input logic rv);
        exp_t e;
        @(posedge clk);
        #3 t = WIDTH'($urandom);
        @(negedge clk);
        reset = rv;
        t     = WIDTH'(tv);
        if (rv) begin
            m_q = m_q ^ (tv & ((1 << WIDTH) - 1));
`ifdef T_FF_TOGGLE_CNT_EN
            if ((tv & ((1 << WIDTH) - 1)) != 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`endif
            e.q   = m_q;
            e.qb  = (~m_q) & ((1 << WIDTH) - 1);
            e.tog = ((tv & ((1 << WIDTH) - 1)) != 0) ? 1 : 0;
            e.cnt = m_cnt;
        end else begin
            m_q   = 0;
            m_cnt = 0;
            e     = reset_exp();
        end
        sb.push_back(e);
    endtask

    // Assert reset between edges and confirm outputs clear before any clock.
    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_q", int'(q), 0);
        chk("async_qb", int'(qb), (1 << WIDTH) - 1);
        chk("async_tog", int'(toggled), 0);
        chk("async_cnt", int'(toggle_cnt), 0);
        m_q   = 0;
        m_cnt = 0;
        sb.push_back(reset_exp());
    endtask

    // Monitor: after each rising edge compare the DUT against the next expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("q", int'(q), e.q);
            chk("qb", int'(qb), e.qb);
            chk("toggled", int'(toggled), e.tog);
            chk("toggle_cnt", int'(toggle_cnt), e.cnt);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        t     = {WIDTH{1'b0}};
        #1 reset = 1'b0;
        #2;
        chk("rst_q", int'(q), 0);
        chk("rst_qb", int'(qb), (1 << WIDTH) - 1);
        chk("rst_tog", int'(toggled), 0);
        chk("rst_cnt", int'(toggle_cnt), 0);

        // reset released, idle for three edges
        for (int i = 0; i < 3; i++) step(0, 1'b1);
        // three toggles of bit 0: q = 1,0,1
        for (int i = 0; i < 3; i++) step(1, 1'b1);
        // idle: q holds, pulse drops
        for (int i = 0; i < 4; i++) step(0, 1'b1);
        // reset while q=1
        async_reset();
        step(5, 1'b0);
        step(15, 1'b0);
        // first edge after release may toggle
        step(15, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15)), 1'b1);
        end
        async_reset();
        step(0, 1'b1);
        // continuous toggling on all bits: divide-by-2 and counter saturation
        for (int i = 0; i < 12; i++) step(15, 1'b1);
        for (int i = 0; i < 30; i++) begin
            step(int'($urandom_range(0, 15)), 1'b1);
        end

        @(posedge clk);
        #2;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/t_ff.md
T_FF -- requirements
Module: t_ff

Interface
REQ-001 Parameter WIDTH, default 1: number of independent toggle flip-flop bits.
REQ-002 Parameter CNT_W, default 16: width of the toggle event counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low (reset=0 resets, reset=1 runs).
REQ-005 t  input  WIDTH  per-bit toggle request, sampled on rising clk.
REQ-006 q  output  WIDTH  registered flip-flop state.
REQ-007 qb  output  WIDTH  bitwise complement of q.
REQ-008 toggled  output  1  registered pulse; 1 for the cycle after any bit of q changed.
REQ-009 toggle_cnt  output  CNT_W  saturating count of clock edges on which any bit toggled.

Function
REQ-010 On each rising clk with reset=1, for every bit i: t[i]=1 -> q[i] becomes ~q[i]; t[i]=0 -> q[i] holds.
REQ-011 qb SHALL equal ~q at all times, including during and immediately after reset; never equal to q.
REQ-012 Latency: a toggle requested by t sampled at edge N is visible on q immediately after edge N (one-edge latency); no combinational path from t to q or qb.
REQ-013 Bits are independent; simultaneous t on several bits toggles each of them on the same edge.
REQ-014 toggled SHALL be 1 in the cycle after an edge on which t!=0 was sampled with reset=1, else 0.
REQ-015 toggle_cnt SHALL increment by 1 on each edge on which t!=0 (regardless of how many bits toggle), and hold at all-ones (2^CNT_W-1) once reached; no wrap-around.
REQ-016 t held at 1 continuously SHALL toggle q on every rising edge (divide-by-2 of clk per bit).
REQ-017 t changing between edges has no effect until the next rising edge; t is assumed synchronous to clk.

Reset
REQ-018 reset=0 SHALL immediately, without waiting for clk, force q=0, qb=all-ones, toggled=0, toggle_cnt=0.
REQ-019 While reset=0, clk edges and t SHALL be ignored; outputs hold reset values.
REQ-020 Reset asserted mid-operation (e.g. during a run of toggles) SHALL discard the in-progress state; no partial update on the reset edge.
REQ-021 After reset deasserts, the first rising clk with reset=1 is the first edge that may toggle q.

Configuration
REQ-022 Macro T_FF_TOGGLE_CNT_EN: when defined, toggle_cnt counter logic is compiled in per REQ-015.
REQ-023 When T_FF_TOGGLE_CNT_EN is not defined, toggle_cnt SHALL be a constant 0 and no counter register SHALL exist; all other behaviour unchanged.

Verification
REQ-024 Clock period 10 ns; reset=0 for first 10 ns, t=0 -> q=0, qb=1 throughout, toggled=0.
REQ-025 Release reset, hold t=0 for 30 ns (3 edges) -> q stays 0, qb stays 1, toggle_cnt=0.
REQ-026 t=1 for 3 consecutive edges from q=0 -> q sequence 1,0,1; qb 0,1,0; toggle_cnt=3 (macro defined).
REQ-027 Then t=0 for 4 edges -> q holds 1, toggled=0 after first idle cycle, toggle_cnt stays 3.
REQ-028 Assert reset=0 between clk edges while q=1 -> q=0, qb=1, toggle_cnt=0 immediately, before next edge.
REQ-029 CNT_W=2, macro defined, t=1 for 6 edges -> toggle_cnt sequence 1,2,3,3,3,3; q alternates each edge.
